// File: rtl/csr_io_responder.sv
// csr_io_responder: responder end of the CSR I/O interface.
//   - Accepts HEX register writes (gpio_we && csr_addr == HEX_ADDR) and acks each one.
//   - Drives eight active-low seven-segment digits decoded from the HEX register.
//   - Synchronises and debounces the switch vector, which is readable at SW_ADDR.
// Optional feature macro: CSR_READBACK_EN (HEX register readable at HEX_ADDR).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   gpio_we               CSR write strobe
//   csr_addr, csr_wdata   CSR address / write data of the current EX instruction
//   csr_rdata             combinational read data to the writeback mux
//   sw_raw                asynchronous board switches
//   hex_reg               current HEX register contents
//   hex_seg               digit i on [7i+6:7i], gfedcba active-low
//   wr_ack                one-cycle pulse per accepted HEX write
module csr_io_responder #(
    parameter int unsigned SW_W            = 18,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic [11:0] HEX_ADDR        = 12'hF02,
    parameter logic [11:0] SW_ADDR         = 12'hF00
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            gpio_we,
    input  logic [11:0]     csr_addr,
    input  logic [31:0]     csr_wdata,
    output logic [31:0]     csr_rdata,
    input  logic [SW_W-1:0] sw_raw,
    output logic [31:0]     hex_reg,
    output logic [55:0]     hex_seg,
    output logic            wr_ack
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } db_state_e;

    logic [31:0]     hex_reg_q, hex_reg_d;
    logic [55:0]     hex_seg_q, hex_seg_d;
    logic            wr_ack_q, wr_ack_d;
    logic [SW_W-1:0] sync1_q, sync1_d;
    logic [SW_W-1:0] sw_sync_q, sw_sync_d;
    logic [SW_W-1:0] sw_stable_q, sw_stable_d;
    logic [SW_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    db_state_e       state_q, state_d;

    // Seven-segment decode of one nibble, gfedcba active-low.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Write path and display reload; the display follows one cycle behind the
    // register, so the ack flop doubles as the reload enable.
    always_comb begin
        hex_reg_d = hex_reg_q;
        wr_ack_d  = 1'b0;
        hex_seg_d = hex_seg_q;
        if (gpio_we && (csr_addr == HEX_ADDR)) begin
            hex_reg_d = csr_wdata;
            wr_ack_d  = 1'b1;
        end
        if (wr_ack_q) begin
            for (int i = 0; i < 8; i++) begin
                hex_seg_d[7*i +: 7] = seg7(hex_reg_q[4*i +: 4]);
            end
        end
    end

    // Two-flop synchroniser and whole-vector debounce FSM.
    always_comb begin
        sync1_d     = sw_raw;
        sw_sync_d   = sync1_q;
        sw_stable_d = sw_stable_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        case (state_q)
            STABLE: begin
                if (sw_sync_q != sw_stable_q) begin
                    cand_d  = sw_sync_q;
                    cnt_d   = '0;
                    state_d = COUNTING;
                end
            end
            default: begin
                if (sw_sync_q == sw_stable_q) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (sw_sync_q != cand_q) begin
                    cand_d = sw_sync_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    sw_stable_d = cand_q;
                    cnt_d       = '0;
                    state_d     = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Combinational read mux.
    always_comb begin
        csr_rdata = 32'h0;
        if (csr_addr == SW_ADDR) begin
            csr_rdata = 32'(sw_stable_q);
        end
`ifdef CSR_READBACK_EN
        else if (csr_addr == HEX_ADDR) begin
            csr_rdata = hex_reg_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_reg_q   <= '0;
            hex_seg_q   <= '1;
            wr_ack_q    <= 1'b0;
            sync1_q     <= '0;
            sw_sync_q   <= '0;
            sw_stable_q <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            state_q     <= STABLE;
        end else begin
            hex_reg_q   <= hex_reg_d;
            hex_seg_q   <= hex_seg_d;
            wr_ack_q    <= wr_ack_d;
            sync1_q     <= sync1_d;
            sw_sync_q   <= sw_sync_d;
            sw_stable_q <= sw_stable_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
        end
    end

    assign hex_reg = hex_reg_q;
    assign hex_seg = hex_seg_q;
    assign wr_ack  = wr_ack_q;

endmodule

// File: tb/tb_csr_io_responder.sv
// Self-checking bench for csr_io_responder (DEBOUNCE_CYCLES reduced to 4).
module tb_csr_io_responder;

    localparam int unsigned SW_W = 18;
    localparam int unsigned DB   = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            gpio_we;
    logic [11:0]     csr_addr;
    logic [31:0]     csr_wdata;
    logic [31:0]     csr_rdata;
    logic [SW_W-1:0] sw_raw;
    logic [31:0]     hex_reg;
    logic [55:0]     hex_seg;
    logic            wr_ack;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [55:0] shown;

    csr_io_responder #(
        .SW_W(SW_W), .DEBOUNCE_CYCLES(DB), .HEX_ADDR(12'hF02), .SW_ADDR(12'hF00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .gpio_we(gpio_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .sw_raw(sw_raw),
        .hex_reg(hex_reg), .hex_seg(hex_seg), .wr_ack(wr_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] nib_seg(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    function automatic logic [55:0] seg_word(input logic [31:0] v);
        logic [55:0] w;
        for (int i = 0; i < 8; i++) w[7*i +: 7] = nib_seg(v[4*i +: 4]);
        return w;
    endfunction

    // Drives one write-strobe cycle at the falling edge; accepted writes are
    // queued as expected hex_reg values.
    task automatic drive_we(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        gpio_we = 1'b1; csr_addr = a; csr_wdata = d;
        if (a == 12'hF02) exp_q.push_back(d);
    endtask

    task automatic idle_bus();
        @(negedge clk);
        gpio_we = 1'b0; csr_addr = 12'hF00; csr_wdata = '0;
    endtask

    // After a posedge with an expected accept: ack must be high and hex_reg
    // must match the oldest queued write.
    task automatic pop_check(input string nm);
        logic [31:0] e;
        total++;
        if (wr_ack !== 1'b1) begin
            bad++; $display("FAIL %s_ack: got %b want 1", nm, wr_ack);
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++; $display("FAIL %s_queue: got empty want entry", nm);
        end else begin
            e = exp_q.pop_front();
            if (hex_reg !== e) begin
                bad++; $display("FAIL %s_reg: got %h want %h", nm, hex_reg, e);
            end
            shown = seg_word(e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; gpio_we = 1'b0; csr_addr = 12'hF00; csr_wdata = '0; sw_raw = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (hex_reg !== 32'h0) begin bad++; $display("FAIL rst_hex_reg: got %h want 0", hex_reg); end
        total++; if (hex_seg !== {56{1'b1}}) begin bad++; $display("FAIL rst_hex_seg: got %h want all ones", hex_seg); end
        total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL rst_wr_ack: got %b want 0", wr_ack); end
        total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", csr_rdata); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_write();
        drive_we(12'hF02, 32'h0000_00A5);
        @(posedge clk); #1;
        pop_check("wr");
        total++; if (hex_seg !== {56{1'b1}}) begin bad++; $display("FAIL wr_seg_lag: got %h want all ones", hex_seg); end
        idle_bus();
        @(posedge clk); #1;
        total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL wr_ack_drop: got %b want 0", wr_ack); end
        total++; if (hex_seg !== {{6{7'h40}}, 7'h08, 7'h12}) begin
            bad++; $display("FAIL wr_seg: got %h want %h", hex_seg, {{6{7'h40}}, 7'h08, 7'h12});
        end
    endtask

    task automatic test_ignore();
        drive_we(12'hF00, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        idle_bus();
        @(posedge clk); #1;
        total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL ign_ack: got %b want 0", wr_ack); end
        total++; if (hex_reg !== 32'h0000_00A5) begin bad++; $display("FAIL ign_reg: got %h want a5", hex_reg); end
        total++; if (hex_seg !== shown) begin bad++; $display("FAIL ign_seg: got %h want %h", hex_seg, shown); end
    endtask

    task automatic test_back_to_back();
        logic [55:0] first;
        drive_we(12'hF02, 32'h0000_0011);
        @(posedge clk); #1;
        pop_check("b2b0");
        first = shown;
        drive_we(12'hF02, 32'h89AB_CDEF);
        @(posedge clk); #1;
        pop_check("b2b1");
        total++; if (hex_seg !== first) begin bad++; $display("FAIL b2b_seg0: got %h want %h", hex_seg, first); end
        idle_bus();
        @(posedge clk); #1;
        total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL b2b_ack_drop: got %b want 0", wr_ack); end
        total++; if (hex_seg !== shown) begin bad++; $display("FAIL b2b_seg1: got %h want %h", hex_seg, shown); end
    endtask

    // Clean change: stable value visible exactly 2 + 1 + DB edges later.
    task automatic test_debounce_clean();
        logic [31:0] e;
        @(negedge clk); sw_raw = 18'h0_0005; csr_addr = 12'hF00;
        for (int k = 1; k <= 3 + DB + 1; k++) begin
            @(posedge clk); #1;
            e = (k >= 3 + DB) ? 32'h5 : 32'h0;
            total++; if (csr_rdata !== e) begin bad++; $display("FAIL db_clean_e%0d: got %h want %h", k, csr_rdata, e); end
        end
        csr_addr = 12'h123; #1;
        total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL db_other_addr: got %h want 0", csr_rdata); end
        csr_addr = 12'hF00;
    endtask

    // Bouncing input: only the final clean level, held long enough, is taken.
    task automatic test_bounce();
        logic [31:0] e;
        @(negedge clk); sw_raw = '0;
        repeat (3 + DB + 3) @(posedge clk);
        #1;
        total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL bnc_settle0: got %h want 0", csr_rdata); end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) sw_raw = 18'h0_0005;
            if (k == 3) sw_raw = 18'h0_0000;
            if (k == 5) sw_raw = 18'h0_0005;
            @(posedge clk); #1;
            e = (k >= 5 + 2 + 1 + DB - 1) ? 32'h5 : 32'h0;
            total++; if (csr_rdata !== e) begin bad++; $display("FAIL bnc_e%0d: got %h want %h", k, csr_rdata, e); end
        end
    endtask

    task automatic test_readback();
        logic [31:0] e;
        drive_we(12'hF02, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        pop_check("rb_wr");
        idle_bus();
        csr_addr = 12'hF02; #1;
`ifdef CSR_READBACK_EN
        e = 32'hDEAD_BEEF;
`else
        e = 32'h0;
`endif
        total++; if (csr_rdata !== e) begin bad++; $display("FAIL rb_read: got %h want %h", csr_rdata, e); end
        drive_we(12'hF02, 32'h0000_0000);
        #1;
        total++; if (csr_rdata !== e) begin bad++; $display("FAIL rb_prewrite: got %h want %h", csr_rdata, e); end
        @(posedge clk); #1;
        pop_check("rb_wr2");
        idle_bus();
    endtask

    task automatic test_reset_mid();
        drive_we(12'hF02, 32'h1234_5678);
        @(posedge clk); #1;
        pop_check("rm_wr");
        #2; rst_n = 1'b0; #1;
        total++; if (hex_reg !== 32'h0) begin bad++; $display("FAIL rm_reg: got %h want 0", hex_reg); end
        total++; if (hex_seg !== {56{1'b1}}) begin bad++; $display("FAIL rm_seg: got %h want all ones", hex_seg); end
        total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL rm_ack: got %b want 0", wr_ack); end
        csr_addr = 12'hF00; #1;
        total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL rm_sw: got %h want 0", csr_rdata); end
        @(negedge clk); gpio_we = 1'b0; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (hex_seg !== {56{1'b1}}) begin bad++; $display("FAIL rm_blank: got %h want all ones", hex_seg); end
    endtask

    initial begin
        shown = '1;
        test_reset();
        test_write();
        test_ignore();
        test_back_to_back();
        test_debounce_clean();
        test_bounce();
        test_readback();
        test_reset_mid();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_io_responder.md
Name: csr_io_responder

Overview:
- Responder end of the CSR I/O interface driven by the EX-stage controller.
- Accepts `csrrw` writes qualified by `gpio_we` and latches the HEX output register at CSR 0xF02.
- Decodes that register into eight active-low seven-segment digits.
- Synchronises and debounces the switch inputs. Presents them as read data at CSR 0xF00 for the register-file writeback path.

Parameters:
- SW_W, 18, width of raw switch vector (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronised cycles required before accepting a new switch value (>=1).
- HEX_ADDR, 12'hF02, CSR address of HEX output register.
- SW_ADDR, 12'hF00, CSR address of switch input register.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- gpio_we  input  1  CSR write strobe from controller.
- csr_addr  input  12  CSR address of current EX instruction.
- csr_wdata  input  32  write data (rs1 value).
- csr_rdata  output  32  read data to regfile writeback mux.
- sw_raw  input  SW_W  asynchronous board switches.
- hex_reg  output  32  current HEX register contents.
- hex_seg  output  56  digit i on bits [7i+6:7i]; each digit encoded gfedcba, active-low; digit 0 = hex_reg[3:0].
- wr_ack  output  1  one-cycle pulse acknowledging an accepted HEX write.

Behaviour:
- Reset (rst_n=0, async), all outputs to these values:
  - hex_reg=0
  - hex_seg=all ones (blank)
  - wr_ack=0
  - sync flops=0
  - sw_stable=0
  - debounce FSM=STABLE, counter=0
- Write path:
  - Accept condition: rising edge with gpio_we=1 and csr_addr==HEX_ADDR.
  - On accept: hex_reg<=csr_wdata and wr_ack<=1 for exactly one cycle.
  - gpio_we=1 with any other address is ignored; no ack, no state change.
  - Back-to-back writes on consecutive cycles each accept; the last one wins; wr_ack stays high across both cycles.
- Display path:
  - hex_seg is registered and reloads from hex_reg one cycle after each accepted write (write at edge N, hex_reg at N, hex_seg at N+1).
  - Display stays blank until the first write after reset.
  - Nibble encodings: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
- Switch path:
  - Two-flop synchroniser per bit produces sw_sync.
  - Debounce FSM treats the whole vector as one unit, with registers sw_stable, cand and counter cnt.
  - STABLE: if sw_sync!=sw_stable, then cand<=sw_sync, cnt<=0, go to COUNTING.
  - COUNTING, evaluated in this priority order:
    1. sw_sync==sw_stable → STABLE, cnt<=0 (bounce back).
    2. sw_sync!=cand → cand<=sw_sync, cnt<=0, stay in COUNTING.
    3. cnt==DEBOUNCE_CYCLES-1 → sw_stable<=cand, go to STABLE.
    4. Otherwise cnt<=cnt+1.
  - cnt width: $clog2(DEBOUNCE_CYCLES+1); cnt never wraps.
  - Latency from a clean sw_raw change to sw_stable update: 2 (sync) + 1 (enter COUNTING) + DEBOUNCE_CYCLES edges.
  - Reset asserted mid-count discards cand; sw_stable returns to 0.
- Read path:
  - Combinational.
  - csr_rdata = zero-extended sw_stable when csr_addr==SW_ADDR, else 0.
- Simultaneous events: a write and a debounce update in the same cycle are independent; both take effect.

Optional Feature:
- Macro: CSR_READBACK_EN.
- Defined: csr_rdata=hex_reg when csr_addr==HEX_ADDR. Read of HEX_ADDR in the same cycle as a write returns the pre-write value (combinational on the register, old value until the edge).
- Undefined: HEX_ADDR reads return 0.

Test Plan:
- Reset, then `gpio_we=1`, `addr=F02`, `wdata=32'h0000_00A5`, one cycle → wr_ack pulse one cycle; hex_reg=0xA5 after edge; next cycle digit0=0x12, digit1=0x08, digits2..7=0x40.
- gpio_we=1, addr=F00, wdata=32'hFFFF_FFFF → no wr_ack; hex_reg and hex_seg unchanged.
- DEBOUNCE_CYCLES=4, sw_raw 0→18'h0_0005 held → csr_rdata (addr F00) reads 0x5 exactly 7 edges after the change, 0 before.
- DEBOUNCE_CYCLES=4, sw_raw toggles 0→5→0→5 every 2 cycles, then holds 5 → sw_stable stays 0 during toggling; becomes 5 only after 4 clean stable cycles.
- Write 32'h1234_5678, assert rst_n=0 mid-cycle → hex_reg=0 and hex_seg all ones immediately (asynchronous), wr_ack=0.
- With CSR_READBACK_EN: write 32'hDEAD_BEEF, read addr F02 → 0xDEADBEEF. Without it: the same read → 0.
